input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The module SHALL expose the following parameters, one per line: name, default, meaning.
- CHANNELS, 5, number of independent input channels.
- SYNC_STAGES, 2, synchronizer flops per channel; minimum 2.
- STABLE_CYCLES, 1000000, consecutive clk cycles a new value must hold before acceptance (10 ms at 100 MHz); minimum 1.
- REPEAT_DELAY, 50000000, cycles from accepted press to first auto-repeat pulse; minimum 1.
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses; minimum 1.
REQ-002 The module SHALL expose the following ports, one per line: name  direction  width  meaning.
- clk  input  1  single system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_in  input  CHANNELS  raw asynchronous switch/button inputs.
- repeat_en  input  CHANNELS  per-channel auto-repeat enable, synchronous to clk.
- btn_level  output  CHANNELS  debounced level.
- btn_rise  output  CHANNELS  one-cycle pulse on debounced 0->1.
- btn_fall  output  CHANNELS  one-cycle pulse on debounced 1->0.
- btn_repeat  output  CHANNELS  one-cycle auto-repeat pulse.
- any_change  output  1  OR of all btn_rise and btn_fall bits in the same cycle.
REQ-003 All counter widths SHALL be derived with $clog2 from the parameters; no truncation at maximum parameter values.

Function
REQ-004 Each channel SHALL pass btn_in through a SYNC_STAGES-deep flop chain; only the last stage is used downstream.
REQ-005 Per channel, a stability counter SHALL increment each cycle the synchronized sample differs from btn_level and clear to 0 in any cycle they match.
REQ-006 When the stability counter would reach STABLE_CYCLES, btn_level SHALL toggle on that edge and the counter SHALL clear.
REQ-007 Acceptance latency SHALL be exactly SYNC_STAGES+STABLE_CYCLES rising edges from the first edge that samples a new stable btn_in value.
REQ-008 Any input excursion shorter than STABLE_CYCLES synchronized cycles SHALL produce no change on any output.
REQ-009 btn_rise/btn_fall SHALL be registered, asserted for exactly one cycle, in the same cycle btn_level takes its new value; a channel never asserts both in one cycle.
REQ-010 Each channel SHALL run a repeat FSM with states IDLE, DELAY, REPEAT and a shared-width repeat counter.
REQ-011 IDLE->DELAY on an accepted rise when repeat_en is 1 in that cycle; counter cleared.
REQ-012 DELAY->REPEAT when REPEAT_DELAY cycles have elapsed since the rise, asserting btn_repeat for one cycle; counter cleared.
REQ-013 In REPEAT, btn_repeat SHALL pulse every REPEAT_PERIOD cycles while the state holds.
REQ-014 From DELAY or REPEAT, an accepted fall or repeat_en=0 SHALL return to IDLE with counter cleared and no btn_repeat that cycle.
REQ-015 Raising repeat_en while already pressed SHALL have no effect until the next accepted rise.
REQ-016 btn_repeat SHALL never coincide with btn_rise on the same channel.
REQ-017 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.

Reset
REQ-018 Asserting reset SHALL immediately, without a clock edge, clear all synchronizer flops, stability and repeat counters, set all FSMs to IDLE and drive every output to 0.
REQ-019 Reset asserted mid-debounce or mid-repeat SHALL discard that progress; after release, an input held at 1 is re-accepted only after full REQ-007 latency and produces a fresh btn_rise.
REQ-020 No output SHALL pulse in the first cycle after reset release.

Verification (CHANNELS=2, SYNC_STAGES=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-021 btn_in[0] 0->1 held -> btn_level[0]=1 exactly 6 edges later, btn_rise[0] and any_change high for that single cycle.
REQ-022 btn_in[0] high for 3 cycles then low -> btn_level, btn_rise, btn_fall, any_change stay 0 throughout.
REQ-023 repeat_en[1]=1, btn_in[1] held -> btn_repeat[1] pulses 10 cycles after btn_rise[1], then every 3 cycles; release -> btn_fall[1], no further repeats.
REQ-024 Ch0 accepted rise and ch1 accepted fall aligned to same cycle -> btn_rise=2'b01, btn_fall=2'b10, any_change=1 for one cycle.
REQ-025 reset pulsed asynchronously during REPEAT -> all outputs 0 before next clk edge; input still held -> new btn_rise 6 edges after release.

Source files
------------

// File: rtl/input_conditioner.sv
// Multi-channel button/switch conditioner. Each channel has a synchronizer,
// a debouncer and an auto-repeat generator. All outputs are registered.
//
// Repeat FSM, one per channel:
//   state  | meaning
//   IDLE   | no auto-repeat; wait for an accepted rise with repeat_en high
//   DELAY  | counting the initial hold time before the first repeat pulse
//   REPEAT | pulsing btn_repeat once every REPEAT_PERIOD cycles
module input_conditioner #(
  parameter int CHANNELS      = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic [CHANNELS-1:0] btn_repeat,
  output logic                any_change
);

  // The stability counter only ever holds 0..STABLE_CYCLES-1; the extra +1
  // keeps the width at least one bit when the parameter is 1.
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_TC = SW'(STABLE_CYCLES - 1);

  // One counter width serves both the initial delay and the repeat period.
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_TC  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_TC = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  logic [CHANNELS-1:0] rise_nxt;
  logic [CHANNELS-1:0] fall_nxt;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SW-1:0]          stab_cnt;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   rep_q;
    rep_state_t             state;
    logic [RW-1:0]          rep_cnt;
    logic                   sample;
    logic                   accept;

    assign sample      = sync_q[SYNC_STAGES-1];
    // Acceptance happens on the edge where the counter would reach STABLE_CYCLES.
    assign accept      = (sample != level_q) && (stab_cnt == STAB_TC);
    assign rise_nxt[c] = accept && !level_q;
    assign fall_nxt[c] = accept && level_q;

    // Synchronizer chain; bit 0 is the first stage to see btn_in.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[c]};
    end

    // Debounce: count consecutive disagreeing cycles, toggle level on terminal count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stab_cnt <= '0;
        level_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        rise_q <= rise_nxt[c];
        fall_q <= fall_nxt[c];
        if (sample == level_q) begin
          stab_cnt <= '0;
        end else if (accept) begin
          stab_cnt <= '0;
          level_q  <= ~level_q;
        end else begin
          stab_cnt <= stab_cnt + SW'(1);
        end
      end
    end

    // Auto-repeat FSM; a fall or dropped enable cancels without a final pulse.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= IDLE;
        rep_cnt <= '0;
        rep_q   <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        case (state)
          IDLE: begin
            if (rise_nxt[c] && repeat_en[c]) begin
              state   <= DELAY;
              rep_cnt <= '0;
            end
          end
          DELAY: begin
            if (fall_nxt[c] || !repeat_en[c]) begin
              state   <= IDLE;
              rep_cnt <= '0;
            end else if (rep_cnt == DELAY_TC) begin
              state   <= REPEAT;
              rep_cnt <= '0;
              rep_q   <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + RW'(1);
            end
          end
          REPEAT: begin
            if (fall_nxt[c] || !repeat_en[c]) begin
              state   <= IDLE;
              rep_cnt <= '0;
            end else if (rep_cnt == PERIOD_TC) begin
              rep_cnt <= '0;
              rep_q   <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + RW'(1);
            end
          end
          default: begin
            state   <= IDLE;
            rep_cnt <= '0;
          end
        endcase
      end
    end

    assign btn_level[c]  = level_q;
    assign btn_rise[c]   = rise_q;
    assign btn_fall[c]   = fall_q;
    assign btn_repeat[c] = rep_q;
  end

  // Registered alongside rise/fall so it lines up with them exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_change <= 1'b0;
    else       any_change <= |(rise_nxt | fall_nxt);
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with small parameters
// (2 channels, 2 sync stages, stable 4, repeat delay 10, period 3).
module tb_input_conditioner;

  logic       clk;
  logic       reset;
  logic [1:0] btn_in;
  logic [1:0] repeat_en;
  logic [1:0] btn_level;
  logic [1:0] btn_rise;
  logic [1:0] btn_fall;
  logic [1:0] btn_repeat;
  logic       any_change;

  int n_checks = 0;
  int n_err    = 0;

  input_conditioner #(
    .CHANNELS(2),
    .SYNC_STAGES(2),
    .STABLE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .repeat_en(repeat_en),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .btn_repeat(btn_repeat),
    .any_change(any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] all_out();
    return {btn_level, btn_rise, btn_fall, btn_repeat};
  endfunction

  initial begin
    reset     = 1'b0;
    btn_in    = 2'b00;
    repeat_en = 2'b00;
    #1 reset = 1'b1;
    #1;
    chk("reset_outputs", {all_out(), any_change}, 9'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("first_cycle_after_release", {all_out(), any_change}, 9'h0);

    // Accepted rise on ch0: level, rise and any_change six edges later.
    btn_in[0] = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      step();
      chk("r21_level", btn_level, (s >= 6) ? 2'b01 : 2'b00);
      chk("r21_rise", btn_rise, (s == 6) ? 2'b01 : 2'b00);
      chk("r21_any", any_change, (s == 6) ? 1 : 0);
    end

    // Accepted fall on ch0.
    btn_in[0] = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      step();
      chk("fall_level", btn_level, (s >= 6) ? 2'b00 : 2'b01);
      chk("fall_pulse", btn_fall, (s == 6) ? 2'b01 : 2'b00);
      chk("fall_rise_quiet", btn_rise, 2'b00);
    end

    // Three-cycle glitch on ch0 must be filtered completely.
    btn_in[0] = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      step();
      chk("r22_glitch_hi", {all_out(), any_change}, 9'h0);
    end
    btn_in[0] = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      step();
      chk("r22_glitch_lo", {all_out(), any_change}, 9'h0);
    end

    // Auto-repeat on ch1; release lands its fall on a would-be repeat slot.
    repeat_en = 2'b10;
    btn_in[1] = 1'b1;
    for (int s = 1; s <= 40; s++) begin
      step();
      chk("r23_rise", btn_rise[1], (s == 6) ? 1 : 0);
      chk("r23_repeat", btn_repeat[1], (s >= 16 && s <= 31 && ((s - 16) % 3 == 0)) ? 1 : 0);
      chk("r23_fall", btn_fall[1], (s == 34) ? 1 : 0);
      chk("r23_level", btn_level[1], (s >= 6 && s < 34) ? 1 : 0);
      chk("r23_ch0_quiet", {btn_level[0], btn_repeat[0]}, 2'b00);
      if (s == 28) btn_in[1] = 1'b0;
    end

    // Simultaneous ch0 rise and ch1 fall.
    repeat_en = 2'b00;
    btn_in[1] = 1'b1;
    for (int s = 1; s <= 7; s++) step();
    chk("r24_setup_level", btn_level, 2'b10);
    btn_in = 2'b01;
    for (int s = 1; s <= 7; s++) begin
      step();
      chk("r24_rise", btn_rise, (s == 6) ? 2'b01 : 2'b00);
      chk("r24_fall", btn_fall, (s == 6) ? 2'b10 : 2'b00);
      chk("r24_any", any_change, (s == 6) ? 1 : 0);
      chk("r24_level", btn_level, (s >= 6) ? 2'b01 : 2'b10);
    end

    // ch0 already pressed when repeat_en rises: no repeats on ch0.
    repeat_en = 2'b11;
    btn_in    = 2'b11;
    for (int s = 1; s <= 20; s++) begin
      step();
      chk("r25_rise", btn_rise, (s == 6) ? 2'b10 : 2'b00);
      chk("r25_repeat", btn_repeat, (s == 16 || s == 19) ? 2'b10 : 2'b00);
    end

    // Asynchronous reset in the middle of REPEAT.
    #2 reset = 1'b1;
    #1;
    chk("r25_async_reset", {all_out(), any_change}, 9'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      step();
      chk("r25_post_rise", btn_rise, (s == 6) ? 2'b11 : 2'b00);
      chk("r25_post_level", btn_level, (s >= 6) ? 2'b11 : 2'b00);
      chk("r25_post_any", any_change, (s == 6) ? 1 : 0);
      chk("r25_post_quiet", {btn_fall, btn_repeat}, 4'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
